// File: rtl/alu_result_packer.sv
// Buffers ALU result words in a small FIFO and serialises them LSB-byte-first
// onto a ready/valid byte stream, flagging any word dropped for lack of space.
module alu_result_packer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_valid,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr
);
    localparam int NBYTES = WIDTH / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shift;
    logic [IDX_W-1:0] idx;

    logic             fifo_empty;
    logic             fifo_full;
    logic             xfer;
    logic             last_xfer;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] shifted;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign head       = mem[rd_ptr];
    assign shifted    = shift >> 8;
    assign xfer       = byte_valid && byte_ready;
    assign last_xfer  = xfer && (idx == LAST_IDX);

    // A pop on the last-byte edge frees a slot, so a full FIFO can still accept.
    assign pop  = !fifo_empty && ((state == IDLE) || last_xfer);
    assign push = alu_valid && (!fifo_full || pop);
    assign drop = alu_valid && fifo_full && !pop;
    assign busy = (state == SEND) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= alu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // byte_out always mirrors the low byte of the shift register while sending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= SEND;
                        shift      <= head;
                        idx        <= '0;
                        byte_out   <= head[7:0];
                        byte_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (last_xfer) begin
                        if (pop) begin
                            shift    <= head;
                            idx      <= '0;
                            byte_out <= head[7:0];
                        end else begin
                            state      <= IDLE;
                            shift      <= '0;
                            idx        <= '0;
                            byte_out   <= '0;
                            byte_valid <= 1'b0;
                        end
                    end else if (xfer) begin
                        shift    <= shifted;
                        idx      <= idx + IDX_W'(1);
                        byte_out <= shifted[7:0];
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_valid <= 1'b0;
                    byte_out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: queue-based reference model compared every cycle,
// directed scenarios with literal byte sequences, then randomized traffic.
module tb_alu_result_packer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int NB    = WIDTH / 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] alu_out;
    logic             alu_valid;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready;
    logic             busy;
    logic             overflow;
    logic             ovf_clr;

    alu_result_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_out    (alu_out),
        .alu_valid  (alu_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 0;

    logic [7:0] got [$];
    int         got_t [$];
    logic [7:0] exp_q [$];

    // Reference model: bytes of the word on the wire, words waiting, sticky flag.
    logic [7:0]       m_cur [$];
    logic [WIDTH-1:0] m_q [$];
    bit               m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_b%0d", name, i), got[i], exp_q[i]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(posedge clk or posedge rst) begin : model
        logic [WIDTH-1:0] w;
        logic [7:0]       b;
        int               n_before;
        bit               popped;
        bit               dropped;
        if (rst) begin
            m_cur.delete();
            m_q.delete();
            m_ovf = 0;
        end else begin
            popped   = 0;
            dropped  = 0;
            n_before = m_q.size();
            if (m_cur.size() != 0 && byte_ready) begin
                b = m_cur.pop_front();
            end
            if (m_cur.size() == 0 && m_q.size() > 0) begin
                w = m_q.pop_front();
                for (int i = 0; i < NB; i++) m_cur.push_back(w[8*i +: 8]);
                popped = 1;
            end
            if (alu_valid) begin
                if (n_before < DEPTH || popped) m_q.push_back(alu_out);
                else dropped = 1;
            end
            if (dropped) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (chk_en && !rst) begin
            check("byte_valid", byte_valid, (m_cur.size() != 0));
            check("byte_out", byte_out, (m_cur.size() != 0) ? m_cur[0] : 8'h00);
            check("busy", busy, (m_cur.size() != 0 || m_q.size() != 0));
            check("overflow", overflow, m_ovf);
            if (byte_valid && byte_ready) begin
                got.push_back(byte_out);
                got_t.push_back(cyc);
            end
        end
    end

    task automatic pulse(input logic [WIDTH-1:0] w);
        alu_out   = w;
        alu_valid = 1'b1;
        step(1);
        alu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alu_out = '0; alu_valid = 1'b0; byte_ready = 1'b0; ovf_clr = 1'b0;
        step(2);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        chk_en = 1;

        // Single word, and first-byte latency
        got.delete();
        byte_ready = 1'b1;
        pulse(16'hA5C3);
        check("lat_edge_k", byte_valid, 0);
        step(1);
        check("lat_edge_k1_valid", byte_valid, 1);
        check("lat_edge_k1_byte", byte_out, 8'hC3);
        step(4);
        exp_q.delete(); exp_q.push_back(8'hC3); exp_q.push_back(8'hA5);
        check_seq("single");
        check("single_idle_valid", byte_valid, 0);
        check("single_idle_busy", busy, 0);

        // Back-pressure on byte 0
        got.delete();
        byte_ready = 1'b0;
        pulse(16'hA5C3);
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", byte_valid, 1);
            check("hold_byte", byte_out, 8'hC3);
            step(1);
        end
        byte_ready = 1'b1;
        step(3);
        check_seq("backpressure");

        // Burst of three into a two-deep FIFO
        got.delete(); got_t.delete();
        pulse(16'h1111); pulse(16'h2222); pulse(16'h3333);
        step(10);
        exp_q.delete();
        exp_q.push_back(8'h11); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h33);
        check_seq("burst");
        if (got_t.size() == 6) check("burst_no_gap", got_t[5] - got_t[0], 5);
        check("burst_ovf", overflow, 0);

        // Overflow, clear, then simultaneous full write and pop
        got.delete();
        byte_ready = 1'b0;
        pulse(16'h1234); pulse(16'h5678); pulse(16'h9ABC); pulse(16'hDEF0);
        check("ovf_set", overflow, 1);
        check("ovf_busy", busy, 1);
        step(2);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        byte_ready = 1'b1;
        step(1);
        pulse(16'hCAFE);
        check("full_pop_write_ovf", overflow, 0);
        step(10);
        exp_q.delete();
        exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h78);
        exp_q.push_back(8'h56); exp_q.push_back(8'hBC); exp_q.push_back(8'h9A);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
        check_seq("full_pop_write");
        check("full_pop_write_ovf_end", overflow, 0);

        // Reset mid-word
        got.delete();
        pulse(16'hBEEF);
        step(2);
        rst = 1'b1;
        #1;
        check("midrst_valid", byte_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_byte", byte_out, 0);
        step(2);
        rst = 1'b0;
        step(6);
        exp_q.delete(); exp_q.push_back(8'hEF);
        check_seq("midrst");

        // Capture on the first edge after reset release
        got.delete();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        pulse(16'h0F5A);
        step(4);
        exp_q.delete(); exp_q.push_back(8'h5A); exp_q.push_back(8'h0F);
        check_seq("post_rst");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            alu_out    = WIDTH'($urandom);
            alu_valid  = ($urandom_range(0, 99) < 40);
            byte_ready = ($urandom_range(0, 99) < 60);
            ovf_clr    = ($urandom_range(0, 99) < 5);
            rst        = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0; alu_valid = 1'b0; ovf_clr = 1'b0; byte_ready = 1'b1;
        step(20);
        check("drain_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
